// File: rtl/xor_unit_arbiter.sv
// Shares one registered WIDTH-bit XOR unit among N_REQ requesters using a round-robin grant.
// Define XOR_ARB_PARITY_EN to register rsp_parity alongside rsp_data; otherwise it is tied to 0.
module xor_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   rsp_parity,
  output logic                   busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic             valid_reg, valid_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [ID_W-1:0]  id_reg, id_next;

  logic [WIDTH-1:0] xor_arr [N_REQ];
  logic             found_hi, found_any;
  logic [ID_W-1:0]  idx_hi, idx_any;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             accept_ok;
  logic             accept;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign xor_arr[gi]   = req_a[gi*WIDTH +: WIDTH] ^ req_b[gi*WIDTH +: WIDTH];
      // Grant is suppressed while reset is asserted even though state is already IDLE.
      assign req_ready[gi] = rst_n & accept & (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Round-robin search: lowest valid index at or above rr_ptr, else lowest valid overall (wrap).
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    idx_hi    = '0;
    idx_any   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found_any = 1'b1;
        idx_any   = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_reg) begin
          found_hi = 1'b1;
          idx_hi   = ID_W'(i);
        end
      end
    end
  end

  assign grant_found = found_any;
  assign grant_idx   = found_hi ? idx_hi : idx_any;
  assign grant_data  = xor_arr[grant_idx];
  assign accept_ok   = (state_reg == IDLE) || rsp_ready;
  assign accept      = grant_found && accept_ok;

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    valid_next  = valid_reg;
    data_next   = data_reg;
    id_next     = id_reg;
    if (accept) begin
      state_next  = RESP;
      valid_next  = 1'b1;
      data_next   = grant_data;
      id_next     = grant_idx;
      rr_ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (state_reg == RESP && rsp_ready) begin
      state_next = IDLE;
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      id_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      valid_reg  <= valid_next;
      data_reg   <= data_next;
      id_reg     <= id_next;
    end
  end

`ifdef XOR_ARB_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= ^grant_data;
    end
  end

  assign rsp_parity = parity_reg;
`else
  assign rsp_parity = 1'b0;
`endif

  assign rsp_valid = valid_reg;
  assign rsp_data  = data_reg;
  assign rsp_id    = id_reg;
  assign busy      = (state_reg == RESP);

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Self-checking bench for xor_unit_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural arbiter model (N_REQ=4, WIDTH=8).
module tb_xor_unit_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ready;
  logic           rsp_parity;
  logic           busy;

  xor_unit_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .rsp_parity(rsp_parity), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  // Behavioural model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  logic         m_par;
  int           m_rr;
  int           last_acc;
  logic [N-1:0] pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic exp_parity(input logic [W-1:0] d);
`ifdef XOR_ARB_PARITY_EN
    return ^d;
`else
    return 1'b0 & d[0];
`endif
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_id = 0; m_par = 1'b0; m_rr = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  endtask

  // One clock: check outputs at the negedge against the model, then advance the model past the posedge.
  task automatic cycle();
    int g;
    logic ok;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    ok = !m_valid || rsp_ready;
    g = model_grant(req_valid, m_rr);
    exp_ready = '0;
    if (g >= 0 && ok) exp_ready[g[1:0]] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("rsp_data", 32'(rsp_data), 32'(m_data));
    check("rsp_id", 32'(rsp_id), 32'(m_id));
    check("rsp_parity", 32'(rsp_parity), 32'(m_par));
    check("busy", 32'(busy), 32'(m_valid));
    @(posedge clk);
    #1;
    last_acc = -1;
    if (g >= 0 && ok) begin
      m_data   = op_a[g] ^ op_b[g];
      m_par    = exp_parity(m_data);
      m_id     = g;
      m_valid  = 1'b1;
      m_rr     = (g + 1) % N;
      last_acc = g;
      $display("t=%0t accept id=%0d data=%02h", $time, g, m_data);
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    last_acc = -1;
    do_reset();
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Round-robin with all requesters continuously valid
    for (int i = 0; i < N; i++) begin op_a[i] = 8'(i); op_b[i] = 8'hFF; end
    drive();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_id", 32'(rsp_id), 32'(k % N));
      check("rr_data", 32'(rsp_data), 32'(8'hFF - 8'(k % N)));
    end

    // Backpressure: response held, no grants, then consume + accept in the same cycle
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_id_hold", 32'(rsp_id), 32'd0);
      check("bp_data_hold", 32'(rsp_data), 32'hFF);
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_next_id", 32'(rsp_id), 32'd1);
    check("bp_next_valid", 32'(rsp_valid), 32'd1);

    // Drain, then a single request from requester 2
    req_valid = '0;
    cycle();
    op_a[2] = 8'hF0; op_b[2] = 8'h3C; drive();
    req_valid = 4'b0100;
    cycle();
    check("single_data", 32'(rsp_data), 32'hCC);
    check("single_id", 32'(rsp_id), 32'd2);
    req_valid = '0;
    cycle();
    check("single_drain", 32'(rsp_valid), 32'd0);
    check("single_hold", 32'(rsp_data), 32'hCC);

    // Skip: move rr_ptr to 1, then 1 and 2 idle while 0 and 3 request
    op_a[0] = 8'h11; op_b[0] = 8'h22; op_a[3] = 8'h55; op_b[3] = 8'h0F; drive();
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b1001;
    cycle();
    check("skip_first", 32'(rsp_id), 32'd3);
    req_valid = 4'b0001;
    cycle();
    check("skip_second", 32'(rsp_id), 32'd0);

    // Parity
    op_a[0] = 8'h01; op_b[0] = 8'h02; drive();
    cycle();
    check("par_data", 32'(rsp_data), 32'h03);
    check("par_zero", 32'(rsp_parity), 32'd0);
    op_a[0] = 8'h07; op_b[0] = 8'h00; drive();
    cycle();
`ifdef XOR_ARB_PARITY_EN
    check("par_one", 32'(rsp_parity), 32'd1);
`else
    check("par_tied", 32'(rsp_parity), 32'd0);
`endif
    req_valid = '0;
    cycle();

    // Asynchronous reset with a response held
    op_a[1] = 8'hA5; op_b[1] = 8'h0F; drive();
    req_valid = 4'b0010; rsp_ready = 1'b0;
    cycle();
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_data", 32'(rsp_data), 32'd0);
    check("arst_id", 32'(rsp_id), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    cycle();
    check("post_rst_grant", 32'(rsp_id), 32'd0);
    req_valid = '0;
    cycle();

    // Randomized traffic; requesters hold until accepted
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          op_a[i] = 8'($urandom);
          op_b[i] = 8'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = pend;
      drive();
      cycle();
      if (last_acc >= 0) pend[last_acc] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
